// File: rtl/traffic_phase_controller.sv
// Run controller for NoC load tests. It steps packet injection through warm-up, measurement,
// drain and flush phases, and gates the traffic generators. It also tags packets created during
// measurement and counts the network-level TX/RX handshakes.
module traffic_phase_controller #(
  parameter int unsigned NODES           = 16,
  parameter int unsigned WARMUP_PACKETS  = 1000,
  parameter int unsigned MEASURE_PACKETS = 5000,
  parameter int unsigned DRAIN_PACKETS   = 3000,
  parameter int unsigned TIMEOUT_CYCLES  = 100000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [NODES-1:0] i_tx_val,
  input  logic [NODES-1:0] i_rx_val,
  input  logic [NODES-1:0] i_rx_meas,
  output logic [2:0]       o_phase,
  output logic             o_inject_en,
  output logic             o_measure_tag,
  output logic [CNT_W-1:0] o_tx_total,
  output logic [CNT_W-1:0] o_rx_total,
  output logic [CNT_W-1:0] o_meas_tx,
  output logic [CNT_W-1:0] o_meas_rx,
  output logic [CNT_W-1:0] o_meas_cycles,
  output logic             o_done,
  output logic             o_timeout
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWarmup  = 3'd1,
    StMeasure = 3'd2,
    StDrain   = 3'd3,
    StFlush   = 3'd4,
    StDone    = 3'd5
  } phase_e;

  localparam logic [CNT_W-1:0] WarmupThr  = CNT_W'(WARMUP_PACKETS);
  localparam logic [CNT_W-1:0] MeasureThr = CNT_W'(MEASURE_PACKETS);
  localparam logic [CNT_W-1:0] DrainThr   = CNT_W'(DRAIN_PACKETS);
  localparam logic [CNT_W-1:0] FlushLast  = CNT_W'(TIMEOUT_CYCLES - 1);

  phase_e           phase_q;
  logic [CNT_W-1:0] phase_cnt_q, flush_cnt_q;
  logic [CNT_W-1:0] tx_total_q, rx_total_q, meas_tx_q, meas_rx_q, meas_cycles_q;
  logic             done_q, timeout_q;

  logic [CNT_W-1:0] tx_n, rx_n, mrx_n;
  logic [CNT_W-1:0] tx_total_next, rx_total_next, phase_sum;
  logic             counting;

  function automatic logic [CNT_W-1:0] popcount(input logic [NODES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NODES; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // Per-cycle handshake counts and the sums the phase transitions compare against
  always_comb begin
    tx_n          = popcount(i_tx_val);
    rx_n          = popcount(i_rx_val);
    mrx_n         = popcount(i_rx_val & i_rx_meas);
    tx_total_next = tx_total_q + tx_n;
    rx_total_next = rx_total_q + rx_n;
    phase_sum     = phase_cnt_q + tx_n;
    counting      = (phase_q == StWarmup) || (phase_q == StMeasure) ||
                    (phase_q == StDrain)  || (phase_q == StFlush);
  end

  // Phase sequencer and all run counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_q       <= StIdle;
      phase_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      tx_total_q    <= '0;
      rx_total_q    <= '0;
      meas_tx_q     <= '0;
      meas_rx_q     <= '0;
      meas_cycles_q <= '0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else if (i_abort) begin
      // Abort beats a simultaneous start; counters keep their values for inspection
      phase_q     <= StIdle;
      phase_cnt_q <= '0;
      flush_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      if (counting) begin
        tx_total_q <= tx_total_next;
        rx_total_q <= rx_total_next;
        meas_rx_q  <= meas_rx_q + mrx_n;
      end
      case (phase_q)
        StIdle, StDone: begin
          if (i_start) begin
            phase_q       <= StWarmup;
            phase_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            tx_total_q    <= '0;
            rx_total_q    <= '0;
            meas_tx_q     <= '0;
            meas_rx_q     <= '0;
            meas_cycles_q <= '0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
          end
        end
        StWarmup: begin
          if (phase_sum >= WarmupThr) begin
            phase_q     <= StMeasure;
            phase_cnt_q <= '0;
          end else begin
            phase_cnt_q <= phase_sum;
          end
        end
        StMeasure: begin
          // Packets accepted in the crossing cycle still count as measured
          meas_tx_q     <= meas_tx_q + tx_n;
          meas_cycles_q <= meas_cycles_q + 1'b1;
          if (phase_sum >= MeasureThr) begin
            phase_q     <= StDrain;
            phase_cnt_q <= '0;
          end else begin
            phase_cnt_q <= phase_sum;
          end
        end
        StDrain: begin
          if (phase_sum >= DrainThr) begin
            phase_q     <= StFlush;
            phase_cnt_q <= '0;
            flush_cnt_q <= '0;
          end else begin
            phase_cnt_q <= phase_sum;
          end
        end
        StFlush: begin
          flush_cnt_q <= flush_cnt_q + 1'b1;
          // Compare the totals as they will stand after this cycle's handshakes
          if (tx_total_next == rx_total_next) begin
            phase_q     <= StDone;
            flush_cnt_q <= '0;
            done_q      <= 1'b1;
            timeout_q   <= 1'b0;
          end else if (flush_cnt_q == FlushLast) begin
            phase_q     <= StDone;
            flush_cnt_q <= '0;
            done_q      <= 1'b1;
            timeout_q   <= 1'b1;
          end
        end
        default: begin
          phase_q     <= StIdle;
          phase_cnt_q <= '0;
          flush_cnt_q <= '0;
        end
      endcase
    end
  end

  // Generator controls decode directly from the registered phase
  always_comb begin
    o_inject_en   = (phase_q == StWarmup) || (phase_q == StMeasure) || (phase_q == StDrain);
    o_measure_tag = (phase_q == StMeasure);
  end

  assign o_phase       = phase_q;
  assign o_tx_total    = tx_total_q;
  assign o_rx_total    = rx_total_q;
  assign o_meas_tx     = meas_tx_q;
  assign o_meas_rx     = meas_rx_q;
  assign o_meas_cycles = meas_cycles_q;
  assign o_done        = done_q;
  assign o_timeout     = timeout_q;

endmodule
